// File: rtl/display_scan_mux_pkg.sv
// Shared constants, scan state type and digit helpers for the 4-digit
// 7-segment scan driver.
package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = 2;
  localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_t;

  function automatic logic [DIGIT_W-1:0] digit_of(input logic [VALUE_W-1:0] v,
                                                  input logic [SEL_W-1:0]   sel);
    logic [DIGIT_W-1:0] d;
    case (sel)
      2'd0:    d = v[3:0];
      2'd1:    d = v[7:4];
      2'd2:    d = v[11:8];
      2'd3:    d = v[15:12];
      default: d = 4'h0;
    endcase
    return d;
  endfunction

  // Digit k is a leading zero when it and every digit above it are zero.
  function automatic logic lz_suppress(input logic [VALUE_W-1:0] v,
                                       input logic [SEL_W-1:0]   sel);
    logic s;
    case (sel)
      2'd0:    s = 1'b0;
      2'd1:    s = (v[15:4]  == 12'h000);
      2'd2:    s = (v[15:8]  == 8'h00);
      2'd3:    s = (v[15:12] == 4'h0);
      default: s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// Control and display-output bundle of the scan driver; the master drives
// the value/control side, the slave (the driver) produces the scan outputs.
interface display_scan_mux_if;
  import disp_pkg::*;

  logic               en;
  logic               load;
  logic [VALUE_W-1:0] value;
  logic               lz_en;
  logic [DIGIT_W-1:0] nibble;
  logic [SEL_W-1:0]   digit_sel;
  logic               blank;
  logic               frame_tick;
  logic               update_ack;

  modport master (
    output en, load, value, lz_en,
    input  nibble, digit_sel, blank, frame_tick, update_ack
  );

  modport slave (
    input  en, load, value, lz_en,
    output nibble, digit_sel, blank, frame_tick, update_ack
  );

endinterface

// File: rtl/display_scan_mux_scan_timer.sv
// Slot timer: counts DIGIT_CYCLES lit cycles then GAP_CYCLES blank cycles
// and strobes advance_o when the digit index must move on.
module scan_timer
  import disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GAP_CYCLES   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output scan_state_t state_d_o,
  output logic        advance_o
);

  localparam int CNT_MAX = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] DIGIT_TC = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             advance_s;

  // Next slot state; everything holds while the scan is disabled.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    advance_s = 1'b0;
    if (en_i) begin
      case (state_q)
        SHOW: begin
          if (cnt_q == DIGIT_TC) begin
            cnt_d = '0;
            if (HAS_GAP) begin
              state_d = GAP;
            end else begin
              advance_s = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_q == GAP_TC) begin
            cnt_d     = '0;
            state_d   = SHOW;
            advance_s = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      endcase
    end else begin
      advance_s = 1'b0;
    end
  end

  // Slot state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_d_o = state_d;
  assign advance_o = advance_s;

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed 4-digit 7-segment scan driver with double-buffered value,
// optional anti-ghosting gap and leading-zero suppression.
module display_scan_mux
  import disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GAP_CYCLES   = 0
) (
  input  logic               clk,
  input  logic               rst,
  display_scan_mux_if.slave  bus
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

  scan_state_t        state_s;
  logic               advance_s;
  logic               wrap_s;

  logic [VALUE_W-1:0] pending_q, pending_d;
  logic               pend_valid_q, pend_valid_d;
  logic [VALUE_W-1:0] shadow_q, shadow_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DIGIT_W-1:0] nibble_q, nibble_d;
  logic               blank_q, blank_d;
  logic               tick_q, tick_d;
  logic               ack_q, ack_d;

  scan_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .en_i      (bus.en),
    .state_d_o (state_s),
    .advance_o (advance_s)
  );

  assign wrap_s = advance_s && (sel_q == LAST_SEL);

  // Buffers, digit index and output next-state; outputs are computed from the
  // next state so the registered outputs line up with the registered index.
  always_comb begin
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    shadow_d     = shadow_q;
    ack_d        = 1'b0;
    tick_d       = wrap_s;
    if (advance_s) begin
      sel_d = sel_q + SEL_ONE;
    end else begin
      sel_d = sel_q;
    end
    // Commit uses the pending value as it was before any same-cycle load.
    if (wrap_s && pend_valid_q) begin
      shadow_d     = pending_q;
      pend_valid_d = 1'b0;
      ack_d        = 1'b1;
    end else begin
      ack_d = 1'b0;
    end
    if (bus.load) begin
      pending_d    = bus.value;
      pend_valid_d = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    nibble_d = digit_of(shadow_d, sel_d);
    blank_d  = (state_s == GAP) | ~bus.en | (bus.lz_en & lz_suppress(shadow_d, sel_d));
  end

  // Output and buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      shadow_q     <= '0;
      sel_q        <= '0;
      nibble_q     <= '0;
      blank_q      <= 1'b0;
      tick_q       <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      shadow_q     <= shadow_d;
      sel_q        <= sel_d;
      nibble_q     <= nibble_d;
      blank_q      <= blank_d;
      tick_q       <= tick_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.nibble     = nibble_q;
  assign bus.digit_sel  = sel_q;
  assign bus.blank      = blank_q;
  assign bus.frame_tick = tick_q;
  assign bus.update_ack = ack_q;

endmodule
